sample_collector: RTL and testbench
===================================

# sample_collector

Receive-side companion to the CHMU address sampler. It accepts the sampler's single-cycle, no-backpressure sampled-address pulses and buffers them in a FIFO. It drains them to the host-facing reader over a valid/ready interface. It counts accepted and dropped samples per epoch and publishes an epoch statistics snapshot at every epoch boundary.

## Interface
Parameters:
- ADDR_SIZE, 21, sampled address width (matches the sampler)
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- CNT_WIDTH, 32, width of the per-epoch statistics counters

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- sample_addr  in  ADDR_SIZE  sampled address from the sampler
- sample_addr_valid  in  1  one-cycle qualifier; there is no ready, so it can never be stalled
- epoch  in  1  epoch level; may stay high for several cycles; only the rising edge acts
- rd_addr  out  ADDR_SIZE  head-of-FIFO address
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  reader accepts the head when rd_valid && rd_ready
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- fifo_full  out  1  fifo_level == DEPTH
- epoch_sample_cnt  out  CNT_WIDTH  accepted samples in the last closed epoch
- epoch_drop_cnt  out  CNT_WIDTH  dropped samples in the last closed epoch
- epoch_stats_valid  out  1  one-cycle pulse when the epoch_* outputs update

## Operation
- Storage:
  - Circular buffer with read and write pointers that are $clog2(DEPTH) bits wide and wrap naturally.
  - A separate occupancy counter drives fifo_level, fifo_full and rd_valid.
- Push:
  - Condition: sample_addr_valid && !fifo_full, with fifo_full taken from the current registered state.
  - Action: store sample_addr at the write pointer, advance the write pointer, and increment live_sample_cnt.
- Drop:
  - Condition: sample_addr_valid && fifo_full.
  - Action: discard the sample and increment live_drop_cnt.
  - A pop in the same cycle does not rescue the sample: fullness is evaluated before the pop.
- Pop:
  - Condition: rd_valid && rd_ready. Advance the read pointer.
  - rd_addr is always the entry at the read pointer (first-word-fall-through).
  - rd_addr is don't-care while rd_valid is 0.
- Simultaneous push and pop when not full or empty:
  - Occupancy is unchanged and both pointers advance.
  - Push into an empty FIFO together with rd_ready: no pop that cycle, because rd_valid was 0.
- Epoch edge detection:
  - epoch_q is a register holding epoch.
  - epoch_rise = epoch && !epoch_q.
- Epoch state machine, two states:
  - RUN: count live statistics. On epoch_rise, move to SNAP.
  - SNAP: lasts one cycle, then returns to RUN.
  - Another epoch_rise cannot occur while in SNAP (it needs epoch low for at least one cycle), so no queueing is needed.
- Snapshot on the epoch_rise cycle:
  - epoch_sample_cnt <= live_sample_cnt plus this cycle's push, if any.
  - epoch_drop_cnt <= live_drop_cnt plus this cycle's drop, if any.
  - Both live counters clear to 0.
  - The boundary sample belongs to the closing epoch.
- epoch_stats_valid pulses high during SNAP, exactly one cycle per rising edge.
- Counter arithmetic:
  - The live counters saturate at 2^CNT_WIDTH−1 and never wrap.
  - The +1 boundary adjustment also saturates.
- The FIFO contents are unaffected by epoch; epoch only touches statistics.

## Timing
- Reset values:
  - rd_valid=0, rd_addr=0, fifo_level=0, fifo_full=0.
  - epoch_sample_cnt=0, epoch_drop_cnt=0, epoch_stats_valid=0.
  - Internal: pointers=0, live counters=0, epoch_q=0, state=RUN.
  - Storage array is not reset.
- Reset asserted mid-operation empties the FIFO and clears all counters immediately (asynchronous). Entries that were in flight are lost and are not counted as drops.
- Push-to-visible latency:
  - A sample pushed at edge N appears with rd_valid=1 after edge N, i.e. it can be popped at edge N+1.
  - Minimum residency is 1 cycle.
- Throughput: one push and one pop per cycle.
- Epoch latency: epoch rises before edge N → snapshot registered at edge N → epoch_stats_valid high for the cycle after edge N (through edge N+1).
- fifo_level and fifo_full update on the same edge as the push or pop that changes them.

## Configuration
- Macro: SAMPLE_COLLECTOR_DEDUP_EN.
- When defined:
  - A push whose address equals the last accepted address is suppressed.
  - A suppressed sample is neither stored nor counted as a sample or a drop.
  - Dropped samples do not update the last-accepted address.
  - A last_valid flag, cleared by reset and on every epoch_rise, guarantees that the first sample of each epoch is always accepted.
- When undefined: every valid sample is pushed or dropped exactly as in Operation, and no comparator or last-address register exists.

## Test plan
- Reset then 3 pushes (0x10, 0x11, 0x12) with rd_ready=0 → fifo_level=3, rd_addr=0x10; set rd_ready=1 → 0x10, 0x11, 0x12 popped on consecutive cycles, then rd_valid=0.
- DEPTH=16, rd_ready=0, 20 consecutive pushes → fifo_full=1 after the 16th; entries 17–20 dropped; epoch rise → epoch_sample_cnt=16, epoch_drop_cnt=4, one-cycle epoch_stats_valid.
- FIFO full with a push and a pop in the same cycle → the push is dropped (drop +1), fifo_level=15.
- Push 0x2A in the same cycle epoch rises, after 5 prior pushes → epoch_sample_cnt=6; next epoch with no samples → epoch_sample_cnt=0; epoch held high for 4 cycles → only one stats pulse.
- Continuous push and pop for 40 cycles at DEPTH=16 → pointer wrap, output order equals input order, fifo_level constant.
- With SAMPLE_COLLECTOR_DEDUP_EN: inputs 0x5, 0x5, 0x6, 0x5 → FIFO holds 0x5, 0x6, 0x5 and sample count is 3; 0x5 after an epoch rise is accepted. Without the macro: all 4 are accepted.

Source files
------------

// File: rtl/sample_collector.sv
// sample_collector
// Receive side of the CHMU address sampler. Sampled-address pulses cannot be
// stalled, so they are pushed into a small first-word-fall-through FIFO and
// drained by the host reader over valid/ready. Accepted and dropped samples
// are counted per epoch. A snapshot of the counts is published on every
// rising edge of the epoch input.
//
// Optional feature, enabled by defining SAMPLE_COLLECTOR_DEDUP_EN:
//   a sample whose address repeats the last accepted address is suppressed.
//   It is not stored and not counted.

module sample_collector #(
  parameter int ADDR_SIZE = 21,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_SIZE-1:0]     sample_addr,
  input  logic                     sample_addr_valid,
  input  logic                     epoch,
  output logic [ADDR_SIZE-1:0]     rd_addr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic [CNT_WIDTH-1:0]     epoch_sample_cnt,
  output logic [CNT_WIDTH-1:0]     epoch_drop_cnt,
  output logic                     epoch_stats_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_SNAP = 1'b1;

  logic [ADDR_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;

  logic [CNT_WIDTH-1:0] live_sample_cnt;
  logic [CNT_WIDTH-1:0] live_drop_cnt;

  logic                 epoch_q;
  logic                 epoch_rise;
  logic [0:0]           state;

  logic                 dup_hit;
  logic                 push;
  logic                 drop;
  logic                 pop;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

`ifdef SAMPLE_COLLECTOR_DEDUP_EN
  logic [ADDR_SIZE-1:0] last_addr;
  logic                 last_valid;

  assign dup_hit = last_valid && (sample_addr == last_addr);
`else
  assign dup_hit = 1'b0;
`endif

  // Fullness comes from the registered occupancy, so a pop in the same
  // cycle cannot make room for an incoming sample
  assign fifo_full  = (level == LVL_W'(DEPTH));
  assign rd_valid   = (level != '0);
  assign fifo_level = level;

  assign push = sample_addr_valid && !dup_hit && !fifo_full;
  assign drop = sample_addr_valid && !dup_hit &&  fifo_full;
  assign pop  = rd_valid && rd_ready;

  // The head is masked while empty so rd_addr reads 0 out of reset,
  // even though the storage array itself is never reset
  assign rd_addr = rd_valid ? mem[rd_ptr] : '0;

  assign epoch_rise        = epoch && !epoch_q;
  assign epoch_stats_valid = (state == ST_SNAP);

  // Sample storage, written at the write pointer on every accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_addr;
    end
  end

  // Pointers wrap naturally; the occupancy counter tracks push/pop balance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Epoch edge detector and the RUN/SNAP sequencer behind the stats pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch_q <= 1'b0;
      state   <= ST_RUN;
    end else begin
      epoch_q <= epoch;
      case (state)
        ST_RUN:  state <= epoch_rise ? ST_SNAP : ST_RUN;
        ST_SNAP: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  // Live counters. On an epoch boundary the cycle's own sample closes out the
  // old epoch and goes into the snapshot, and the live counters restart at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_sample_cnt  <= '0;
      live_drop_cnt    <= '0;
      epoch_sample_cnt <= '0;
      epoch_drop_cnt   <= '0;
    end else if (epoch_rise) begin
      epoch_sample_cnt <= push ? sat_inc(live_sample_cnt) : live_sample_cnt;
      epoch_drop_cnt   <= drop ? sat_inc(live_drop_cnt)   : live_drop_cnt;
      live_sample_cnt  <= '0;
      live_drop_cnt    <= '0;
    end else begin
      if (push) begin
        live_sample_cnt <= sat_inc(live_sample_cnt);
      end
      if (drop) begin
        live_drop_cnt <= sat_inc(live_drop_cnt);
      end
    end
  end

`ifdef SAMPLE_COLLECTOR_DEDUP_EN
  // Remember the last accepted address. Forget it at each epoch boundary so
  // that the first sample of a new epoch always gets through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else begin
      if (push) begin
        last_addr <= sample_addr;
      end
      if (epoch_rise) begin
        last_valid <= 1'b0;
      end else if (push) begin
        last_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sample_collector.sv
// Self-checking bench for sample_collector at its default parameters.
// Expected FIFO contents are queued as samples are driven. A monitor pops
// and compares them as the reader takes each entry.
// Honours SAMPLE_COLLECTOR_DEDUP_EN the same way the design does.

module tb_sample_collector;

  localparam int AW    = 21;
  localparam int DEPTH = 16;
  localparam int CW    = 32;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   sample_addr;
  logic            sample_addr_valid;
  logic            epoch;
  logic [AW-1:0]   rd_addr;
  logic            rd_valid;
  logic            rd_ready;
  logic [4:0]      fifo_level;
  logic            fifo_full;
  logic [CW-1:0]   epoch_sample_cnt;
  logic [CW-1:0]   epoch_drop_cnt;
  logic            epoch_stats_valid;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mdl_last;
  logic          mdl_last_valid;
  logic          prev_ep;
  int            live_s;
  int            live_d;
  int            snap_s;
  int            snap_d;

  sample_collector #(
    .ADDR_SIZE(AW),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_addr(sample_addr),
    .sample_addr_valid(sample_addr_valid),
    .epoch(epoch),
    .rd_addr(rd_addr),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .fifo_level(fifo_level),
    .fifo_full(fifo_full),
    .epoch_sample_cnt(epoch_sample_cnt),
    .epoch_drop_cnt(epoch_drop_cnt),
    .epoch_stats_valid(epoch_stats_valid)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard consumer: whenever the reader is about to take the head,
  // it must equal the oldest expected sample
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected: got rd_addr=0x%0h, expected no valid entry", rd_addr);
      end else begin
        if (rd_addr !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL pop_order: got rd_addr=0x%0h, expected 0x%0h", rd_addr, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of inputs and update the reference model. Returns 1 ns
  // after the edge that registers them
  task automatic drive(input logic [AW-1:0] a, input logic v, input logic rdy, input logic ep);
    logic dup;
    logic full;
    sample_addr       = a;
    sample_addr_valid = v;
    rd_ready          = rdy;
    epoch             = ep;
`ifdef SAMPLE_COLLECTOR_DEDUP_EN
    dup = mdl_last_valid && (a == mdl_last);
`else
    dup = 1'b0;
`endif
    full = (exp_q.size() == DEPTH);
    if (v && !dup) begin
      if (!full) begin
        exp_q.push_back(a);
        live_s++;
        mdl_last       = a;
        mdl_last_valid = 1'b1;
      end else begin
        live_d++;
      end
    end
    if (ep && !prev_ep) begin
      snap_s         = live_s;
      snap_d         = live_d;
      live_s         = 0;
      live_d         = 0;
      mdl_last_valid = 1'b0;
    end
    prev_ep = ep;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    sample_addr       = '0;
    sample_addr_valid = 1'b0;
    rd_ready          = 1'b0;
    epoch             = 1'b0;
    exp_q.delete();
    mdl_last       = '0;
    mdl_last_valid = 1'b0;
    prev_ep        = 1'b0;
    live_s = 0;
    live_d = 0;
    snap_s = 0;
    snap_d = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Let the reader empty the FIFO within a fixed cycle budget
  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) break;
      drive('0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (exp_q.size() != 0 || rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain: got rd_valid=%0b with %0d expected entries left, expected empty",
               rd_valid, exp_q.size());
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    checks++;
    if (rd_valid !== 1'b0 || rd_addr !== '0 || fifo_level !== 5'd0 || fifo_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_fifo: got valid=%0b addr=0x%0h level=%0d full=%0b, expected 0/0/0/0",
               rd_valid, rd_addr, fifo_level, fifo_full);
    end
    checks++;
    if (epoch_sample_cnt !== '0 || epoch_drop_cnt !== '0 || epoch_stats_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_stats: got samples=%0d drops=%0d valid=%0b, expected 0/0/0",
               epoch_sample_cnt, epoch_drop_cnt, epoch_stats_valid);
    end
    drive(21'h0A1, 1'b1, 1'b0, 1'b0);
    drive(21'h0A2, 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_level !== 5'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: got level=%0d valid=%0b, expected 0/0 right after reset",
               fifo_level, rd_valid);
    end
    do_reset();
    drive('0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (epoch_sample_cnt !== '0 || epoch_drop_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_lost_not_counted: got samples=%0d drops=%0d, expected 0/0",
               epoch_sample_cnt, epoch_drop_cnt);
    end
    drive('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    $display("[TB] test_basic");
    do_reset();
    drive(21'h10, 1'b1, 1'b0, 1'b0);
    drive(21'h11, 1'b1, 1'b0, 1'b0);
    drive(21'h12, 1'b1, 1'b0, 1'b0);
    sample_addr_valid = 1'b0;
    checks++;
    if (fifo_level !== 5'd3 || rd_addr !== 21'h10 || rd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_fill: got level=%0d head=0x%0h valid=%0b, expected 3/0x10/1",
               fifo_level, rd_addr, rd_valid);
    end
    for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || fifo_level !== 5'd0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_drain: got valid=%0b level=%0d left=%0d, expected 0/0/0",
               rd_valid, fifo_level, exp_q.size());
    end
  endtask

  task automatic test_full_drop();
    $display("[TB] test_full_drop");
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(21'h100 + AW'(i), 1'b1, 1'b0, 1'b0);
      if (i == 15) begin
        checks++;
        if (fifo_full !== 1'b1 || fifo_level !== 5'd16) begin
          errors++;
          $display("[TB] FAIL full_after_16: got full=%0b level=%0d, expected 1/16", fifo_full, fifo_level);
        end
      end
    end
    checks++;
    if (fifo_level !== 5'd16 || rd_addr !== 21'h100) begin
      errors++;
      $display("[TB] FAIL full_hold: got level=%0d head=0x%0h, expected 16/0x100", fifo_level, rd_addr);
    end
    drive('0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (epoch_stats_valid !== 1'b1 || epoch_sample_cnt !== 32'd16 || epoch_drop_cnt !== 32'd4 ||
        snap_s != 16 || snap_d != 4) begin
      errors++;
      $display("[TB] FAIL full_stats: got valid=%0b samples=%0d drops=%0d, expected 1/16/4",
               epoch_stats_valid, epoch_sample_cnt, epoch_drop_cnt);
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (epoch_stats_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_stats_pulse: got valid=%0b one cycle later, expected 0", epoch_stats_valid);
    end
  endtask

  task automatic test_full_push_pop();
    $display("[TB] test_full_push_pop");
    drive(21'h200, 1'b1, 1'b1, 1'b0);
    checks++;
    if (fifo_level !== 5'd15 || fifo_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_pushpop_level: got level=%0d full=%0b, expected 15/0", fifo_level, fifo_full);
    end
    drive('0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (epoch_drop_cnt !== 32'd1 || epoch_sample_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL full_pushpop_drop: got samples=%0d drops=%0d, expected 0/1",
               epoch_sample_cnt, epoch_drop_cnt);
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_epoch_boundary();
    int pulses;
    $display("[TB] test_epoch_boundary");
    do_reset();
    for (int i = 0; i < 5; i++) drive(21'h20 + AW'(i), 1'b1, 1'b1, 1'b0);
    drive(21'h2A, 1'b1, 1'b1, 1'b1);
    sample_addr_valid = 1'b0;
    checks++;
    if (epoch_stats_valid !== 1'b1 || epoch_sample_cnt !== 32'd6 || epoch_drop_cnt !== 32'd0 ||
        snap_s != 6) begin
      errors++;
      $display("[TB] FAIL boundary_sample: got valid=%0b samples=%0d drops=%0d, expected 1/6/0",
               epoch_stats_valid, epoch_sample_cnt, epoch_drop_cnt);
    end
    pulses = 1;
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b0, 1'b1, 1'b1);
      if (epoch_stats_valid === 1'b1) pulses++;
    end
    drive('0, 1'b0, 1'b1, 1'b0);
    if (epoch_stats_valid === 1'b1) pulses++;
    drive('0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (epoch_stats_valid !== 1'b1 || epoch_sample_cnt !== 32'd0 || epoch_drop_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL empty_epoch: got valid=%0b samples=%0d drops=%0d, expected 1/0/0",
               epoch_stats_valid, epoch_sample_cnt, epoch_drop_cnt);
    end
    pulses++;
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b0, 1'b1, 1'b1);
      if (epoch_stats_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("[TB] FAIL held_epoch_pulses: got %0d stats pulses over two raised epochs, expected 2", pulses);
    end
    drive('0, 1'b0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int bad_level;
    $display("[TB] test_back_to_back");
    do_reset();
    bad_level = 0;
    for (int i = 0; i < 40; i++) begin
      drive(21'h300 + AW'(i), 1'b1, 1'b1, 1'b0);
      if (fifo_level !== 5'd1) bad_level++;
    end
    sample_addr_valid = 1'b0;
    checks++;
    if (bad_level != 0) begin
      errors++;
      $display("[TB] FAIL b2b_level: got %0d cycles with level!=1, expected 0", bad_level);
    end
    drain();
    drive('0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (epoch_sample_cnt !== 32'd40 || epoch_drop_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL b2b_stats: got samples=%0d drops=%0d, expected 40/0",
               epoch_sample_cnt, epoch_drop_cnt);
    end
    drive('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_dedup();
    logic [4:0]  exp_lvl1;
    logic [4:0]  exp_lvl2;
    logic [31:0] exp_cnt;
    $display("[TB] test_dedup");
`ifdef SAMPLE_COLLECTOR_DEDUP_EN
    exp_lvl1 = 5'd3;
    exp_lvl2 = 5'd4;
    exp_cnt  = 32'd3;
`else
    exp_lvl1 = 5'd4;
    exp_lvl2 = 5'd5;
    exp_cnt  = 32'd4;
`endif
    do_reset();
    drive(21'h5, 1'b1, 1'b0, 1'b0);
    drive(21'h5, 1'b1, 1'b0, 1'b0);
    drive(21'h6, 1'b1, 1'b0, 1'b0);
    drive(21'h5, 1'b1, 1'b0, 1'b0);
    sample_addr_valid = 1'b0;
    checks++;
    if (fifo_level !== exp_lvl1) begin
      errors++;
      $display("[TB] FAIL dedup_level: got level=%0d, expected %0d", fifo_level, exp_lvl1);
    end
    drive('0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (epoch_sample_cnt !== exp_cnt || epoch_drop_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL dedup_count: got samples=%0d drops=%0d, expected %0d/0",
               epoch_sample_cnt, epoch_drop_cnt, exp_cnt);
    end
    drive(21'h5, 1'b1, 1'b0, 1'b0);
    sample_addr_valid = 1'b0;
    checks++;
    if (fifo_level !== exp_lvl2) begin
      errors++;
      $display("[TB] FAIL dedup_after_epoch: got level=%0d, expected %0d", fifo_level, exp_lvl2);
    end
    drain();
  endtask

  // Scenario sequence
  initial begin
    rst = 1'b1;
    sample_addr = '0;
    sample_addr_valid = 1'b0;
    rd_ready = 1'b0;
    epoch = 1'b0;
    test_reset();
    test_basic();
    test_full_drop();
    test_full_push_pop();
    test_epoch_boundary();
    test_back_to_back();
    test_dedup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
